// File: rtl/key_debounce_multi.sv
// Multi-channel front-panel key conditioner: 2-flop sync, debounce filter and
// press / release / long-press / auto-repeat pulse decode per channel.
module key_debounce_multi #(
  parameter int NUM_KEYS     = 4,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter int REPEAT_EN    = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [NUM_KEYS-1:0]   key_in,
  output logic [NUM_KEYS-1:0]   key_state,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic [NUM_KEYS-1:0]   key_release,
  output logic [NUM_KEYS-1:0]   key_long,
  output logic [NUM_KEYS-1:0]   key_repeat,
  output logic [2*NUM_KEYS-1:0] dbg_state
);

  // dbg_state carries each channel's FSM state, channel k in bits [2k+1:2k].
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    HELD       = 2'd2,
    REL_FILT   = 2'd3
  } key_fsm_e;

  localparam int DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] L_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYC - 1);
  localparam logic INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic          sync1_q, sync2_q, p;
    key_fsm_e      state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d, release_q, release_d;
    logic          long_q, long_d, repeat_q, repeat_d;

    assign p = sync2_q ^ INACTIVE;

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        sync1_q     <= INACTIVE;
        sync2_q     <= INACTIVE;
        state_q     <= IDLE;
        dcnt_q      <= '0;
        hcnt_q      <= '0;
        long_done_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        sync1_q     <= key_in[g];
        sync2_q     <= sync1_q;
        state_q     <= state_d;
        dcnt_q      <= dcnt_d;
        hcnt_q      <= hcnt_d;
        long_done_q <= long_done_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
        long_q      <= long_d;
        repeat_q    <= repeat_d;
      end
    end

    always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      hcnt_d      = hcnt_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;
      repeat_d    = 1'b0;
      case (state_q)
        IDLE: begin
          dcnt_d = '0;
          if (p) begin
            state_d = PRESS_FILT;
            dcnt_d  = DW'(1);
          end
        end
        PRESS_FILT: begin
          if (!p) begin
            state_d = IDLE;
            dcnt_d  = '0;
          end else if (dcnt_q == D_LAST) begin
            state_d     = HELD;
            dcnt_d      = '0;
            press_d     = 1'b1;
            level_d     = 1'b1;
            hcnt_d      = '0;
            long_done_d = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        HELD: begin
          // hcnt stalls once long has fired with repeat disabled, so it never wraps.
          if (!p) begin
            state_d = REL_FILT;
            dcnt_d  = DW'(1);
          end else if (!long_done_q) begin
            if (hcnt_q == L_LAST) begin
              long_d      = 1'b1;
              long_done_d = 1'b1;
              hcnt_d      = '0;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end else if (REPEAT_EN != 0) begin
            if (hcnt_q == R_LAST) begin
              repeat_d = 1'b1;
              hcnt_d   = '0;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        REL_FILT: begin
          if (p) begin
            state_d = HELD;
            dcnt_d  = '0;
          end else if (dcnt_q == D_LAST) begin
            state_d   = IDLE;
            dcnt_d    = '0;
            release_d = 1'b1;
            level_d   = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: begin
          state_d     = IDLE;
          dcnt_d      = '0;
          hcnt_d      = '0;
          long_done_d = 1'b0;
          level_d     = 1'b0;
        end
      endcase
    end

    assign key_state[g]         = level_q;
    assign key_press[g]         = press_q;
    assign key_release[g]       = release_q;
    assign key_long[g]          = long_q;
    assign key_repeat[g]        = repeat_q;
    assign dbg_state[2*g +: 2]  = state_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: two instances (repeat on / repeat off) driven
// by one key stream and compared every cycle against a run-length event model.
module tb_key_debounce_multi;
  localparam int NK = 4;
  localparam int DB = 8;
  localparam int LG = 40;
  localparam int RP = 10;

  logic          sys_clk = 1'b0;
  logic          rst     = 1'b1;
  logic [NK-1:0] key_in  = '1;
  logic [NK-1:0] st_a, pr_a, rl_a, lg_a, rp_a;
  logic [NK-1:0] st_b, pr_b, rl_b, lg_b, rp_b;
  logic [2*NK-1:0] dbg_a, dbg_b;
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  key_debounce_multi #(.NUM_KEYS(NK), .DEBOUNCE_CYC(DB), .LONG_CYC(LG), .REPEAT_CYC(RP),
                       .REPEAT_EN(1), .ACTIVE_LOW(1)) dut_rep (
    .sys_clk(sys_clk), .rst(rst), .key_in(key_in), .key_state(st_a), .key_press(pr_a),
    .key_release(rl_a), .key_long(lg_a), .key_repeat(rp_a), .dbg_state(dbg_a));

  key_debounce_multi #(.NUM_KEYS(NK), .DEBOUNCE_CYC(DB), .LONG_CYC(LG), .REPEAT_CYC(RP),
                       .REPEAT_EN(0), .ACTIVE_LOW(1)) dut_norep (
    .sys_clk(sys_clk), .rst(rst), .key_in(key_in), .key_state(st_b), .key_press(pr_b),
    .key_release(rl_b), .key_long(lg_b), .key_repeat(rp_b), .dbg_state(dbg_b));

  // Reference model: a press is accepted after DB consecutive pressed samples,
  // a release after DB consecutive released samples; hold ticks are cycles spent
  // held with the level pressed now and on the previous sample.
  typedef struct packed {
    logic mode;
    logic pprev;
    int   run;
    int   ticks;
    logic st, pr, rl, lg, rp;
  } ch_t;

  function automatic ch_t step(ch_t c, logic p);
    ch_t n = c;
    n.pr = 1'b0; n.rl = 1'b0; n.lg = 1'b0; n.rp = 1'b0;
    if (!c.mode) begin
      n.run = p ? c.run + 1 : 0;
      if (n.run == DB) begin
        n.mode = 1'b1; n.st = 1'b1; n.pr = 1'b1; n.run = 0; n.ticks = 0;
      end
    end else begin
      if (p && c.pprev) begin
        n.ticks = c.ticks + 1;
        if (n.ticks == LG) n.lg = 1'b1;
        if (n.ticks > LG && (n.ticks - LG) % RP == 0) n.rp = 1'b1;
      end
      n.run = p ? 0 : c.run + 1;
      if (n.run == DB) begin
        n.mode = 1'b0; n.st = 1'b0; n.rl = 1'b1; n.run = 0;
      end
    end
    n.pprev = p;
    return n;
  endfunction

  logic [NK-1:0] h1, h2;
  ch_t m_q[NK];
  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      h1 <= '0;
      h2 <= '0;
      for (int k = 0; k < NK; k++) m_q[k] <= '0;
    end else begin
      h1 <= ~key_in;
      h2 <= h1;
      for (int k = 0; k < NK; k++) m_q[k] <= step(m_q[k], h2[k]);
    end
  end

  logic [NK-1:0] e_st, e_pr, e_rl, e_lg, e_rp;
  always_comb begin
    e_st = '0; e_pr = '0; e_rl = '0; e_lg = '0; e_rp = '0;
    for (int k = 0; k < NK; k++) begin
      e_st[k] = m_q[k].st; e_pr[k] = m_q[k].pr; e_rl[k] = m_q[k].rl;
      e_lg[k] = m_q[k].lg; e_rp[k] = m_q[k].rp;
    end
  end

  logic [10*NK-1:0] obs_all, exp_all;
  assign obs_all = {st_a, pr_a, rl_a, lg_a, rp_a, st_b, pr_b, rl_b, lg_b, rp_b};
  assign exp_all = {e_st, e_pr, e_rl, e_lg, e_rp, e_st, e_pr, e_rl, e_lg, {NK{1'b0}}};

  task automatic drive_cycle(input logic [NK-1:0] keys);
    key_in = keys;
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_in = '1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if ({obs_all, dbg_a, dbg_b} !== '0) begin
        bad++; $display("FAIL reset_outputs c%0d: got %h expected 0", i, obs_all);
      end
      total++;
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle('1);
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL reset_idle c%0d: got %h expected %h", i, obs_all, exp_all);
      end
      total++;
    end
  endtask

  task automatic test_short_bounce();
    int seen;
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      drive_cycle((i <= 5) ? 4'b1110 : 4'b1111);
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL bounce_model e%0d: got %h expected %h", i, obs_all, exp_all);
      end
      total++;
      if (pr_a[0] || st_a[0]) seen++;
    end
    if (seen !== 0) begin
      bad++; $display("FAIL bounce_no_event: got %0d event cycles expected 0", seen);
    end
    total++;
  endtask

  task automatic test_hold_repeat();
    int press_e, long_e, rel_e, st_err;
    logic [31:0] want;
    press_e = -1; long_e = -1; rel_e = -1; st_err = 0;
    exp_q.delete();
    for (int r = 60; r <= 100; r += RP) exp_q.push_back(32'(r));
    for (int i = 1; i <= 125; i++) begin
      drive_cycle((i <= 100) ? 4'b1110 : 4'b1111);
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL hold_model e%0d: got %h expected %h", i, obs_all, exp_all);
      end
      total++;
      if (pr_a[0]) press_e = i;
      if (lg_a[0]) long_e = i;
      if (rl_a[0]) rel_e = i;
      if (st_a[0] !== ((i >= 10) && (i < 110))) st_err++;
      if (rp_a[0]) begin
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL hold_extra_repeat: got repeat at e%0d expected none", i);
        end else begin
          want = exp_q.pop_front();
          if (32'(i) !== want) begin
            bad++; $display("FAIL hold_repeat_edge: got e%0d expected e%0d", i, want);
          end
        end
        total++;
      end
    end
    if (press_e !== 10) begin bad++; $display("FAIL hold_press_edge: got %0d expected 10", press_e); end
    total++;
    if (long_e !== 50) begin bad++; $display("FAIL hold_long_edge: got %0d expected 50", long_e); end
    total++;
    if (rel_e !== 110) begin bad++; $display("FAIL hold_release_edge: got %0d expected 110", rel_e); end
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL hold_missing_repeat: got %0d left expected 0", exp_q.size());
    end
    total++;
    if (st_err !== 0) begin bad++; $display("FAIL hold_state_window: got %0d bad cycles expected 0", st_err); end
    total++;
  endtask

  task automatic test_bounce_held();
    int npress, nrel, long_e, rel_e;
    logic [NK-1:0] keys;
    npress = 0; nrel = 0; long_e = -1; rel_e = -1;
    for (int i = 1; i <= 95; i++) begin
      keys = '1;
      if (i <= 70 && !(i >= 20 && i <= 23)) keys[1] = 1'b0;
      drive_cycle(keys);
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL held_bounce_model e%0d: got %h expected %h", i, obs_all, exp_all);
      end
      total++;
      if (pr_a[1]) npress++;
      if (rl_a[1]) begin nrel++; rel_e = i; end
      if (lg_a[1]) long_e = i;
    end
    if (npress !== 1) begin bad++; $display("FAIL held_bounce_presses: got %0d expected 1", npress); end
    total++;
    if (nrel !== 1) begin bad++; $display("FAIL held_bounce_releases: got %0d expected 1", nrel); end
    total++;
    if (rel_e !== 80) begin bad++; $display("FAIL held_bounce_rel_edge: got %0d expected 80", rel_e); end
    total++;
    if (long_e !== 55) begin bad++; $display("FAIL held_bounce_long_edge: got %0d expected 55", long_e); end
    total++;
  endtask

  task automatic test_simultaneous();
    int nrep_a, nrep_b;
    nrep_a = 0; nrep_b = 0;
    for (int i = 1; i <= 100; i++) begin
      drive_cycle((i <= 80) ? 4'b0110 : 4'b1111);
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL simul_model e%0d: got %h expected %h", i, obs_all, exp_all);
      end
      total++;
      if (i == 10) begin
        if ({pr_a, pr_b} !== 8'b1001_1001) begin
          bad++; $display("FAIL simul_press: got %b expected 10011001", {pr_a, pr_b});
        end
        total++;
      end
      if (i == 50) begin
        if ({lg_a, lg_b} !== 8'b1001_1001) begin
          bad++; $display("FAIL simul_long: got %b expected 10011001", {lg_a, lg_b});
        end
        total++;
      end
      if (rp_a !== '0) nrep_a++;
      if (rp_b !== '0) nrep_b++;
    end
    if (nrep_a !== 3) begin bad++; $display("FAIL simul_repeat_cnt: got %0d expected 3", nrep_a); end
    total++;
    if (nrep_b !== 0) begin bad++; $display("FAIL simul_norepeat: got %0d expected 0", nrep_b); end
    total++;
  endtask

  task automatic test_reset_mid_hold();
    int found, nrel;
    found = -1; nrel = 0;
    for (int i = 1; i <= 60; i++) begin
      drive_cycle(4'b1011);
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL midrst_model e%0d: got %h expected %h", i, obs_all, exp_all);
      end
      total++;
      if (rl_a[2] || rl_b[2]) nrel++;
    end
    if (st_a[2] !== 1'b1) begin bad++; $display("FAIL midrst_pre_state: got %b expected 1", st_a[2]); end
    total++;
    #2 rst = 1'b1;
    #1;
    if (obs_all !== '0) begin bad++; $display("FAIL midrst_async: got %h expected 0", obs_all); end
    total++;
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      drive_cycle(4'b1011);
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL midrst_after e%0d: got %h expected %h", i, obs_all, exp_all);
      end
      total++;
      if (rl_a[2] || rl_b[2]) nrel++;
      if (pr_a[2] && found < 0) found = i;
    end
    if (found !== DB + 2) begin bad++; $display("FAIL midrst_repress: got %0d expected %0d", found, DB + 2); end
    total++;
    if (nrel !== 0) begin bad++; $display("FAIL midrst_no_release: got %0d expected 0", nrel); end
    total++;
    for (int i = 1; i <= 20; i++) begin
      drive_cycle($urandom_range(15, 0) >= 12 ? 4'b1011 : 4'b1111);
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL midrst_tail e%0d: got %h expected %h", i, obs_all, exp_all);
      end
      total++;
    end
  endtask

  task automatic test_random();
    logic [NK-1:0] keys;
    int hold [NK];
    keys = '1;
    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int i = 1; i <= 3000; i++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          keys[k] = ~keys[k];
          hold[k] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(12, 1))
                                                 : int'($urandom_range(90, 5));
        end
        hold[k]--;
      end
      drive_cycle(keys);
      if (obs_all !== exp_all) begin
        bad++; $display("FAIL random_model e%0d: got %h expected %h", i, obs_all, exp_all);
      end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_short_bounce();
    test_hold_repeat();
    test_bounce_held();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
